king_scsi_dma_seq: RTL

//  Data-in DMA sequencer for the KING SCSI port (CD-ROM reads). Once armed with a byte count, it runs the REQ/ACK handshake autonomously.

---
 rtl/king_scsi_dma_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/king_scsi_dma_seq.sv
// KING SCSI data-in DMA sequencer.
// Runs REQ/ACK per byte and packs bytes into 16-bit KRAM words.
module king_scsi_dma_seq #(
  parameter int CNT_W    = 18,
  parameter int ACK_HOLD = 2,
  parameter int ACK_GAP  = 2
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic             ce_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] byte_cnt_i,
  input  logic [7:0]       scsi_di_i,
  input  logic             scsi_reqn_i,
  input  logic             scsi_ion_i,
  input  logic             scsi_cdn_i,
  input  logic             scsi_msgn_i,
  output logic             scsi_ackn_o,
  output logic [15:0]      wr_data_o,
  output logic             wr_valid_o,
  input  logic             wr_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             phase_err_o,
  output logic [CNT_W-1:0] remain_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_ACK_ON,
    S_ACK_OFF,
    S_FLUSH
  } state_e;

  localparam int TW = 8;
  localparam logic [TW-1:0] HOLD_LAST = TW'(ACK_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(ACK_GAP - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             perr_q, perr_d;
  logic             done_q, done_d;
  logic             vld_q, vld_d;
  logic [15:0]      data_q, data_d;
  logic [7:0]       lo_q, lo_d;
  logic             lo_full_q, lo_full_d;

  logic acc;
  logic phase_ok;
  logic can_store;

  assign acc       = vld_q & wr_ready_i;
  assign phase_ok  = ~scsi_ion_i & scsi_cdn_i & scsi_msgn_i;
  assign can_store = ~lo_full_q | ~vld_q | acc;

  // Next-state, packer and counter updates for one CE cycle
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    remain_d  = remain_q;
    perr_d    = perr_q;
    done_d    = 1'b0;
    vld_d     = vld_q & ~acc;
    data_d    = data_q;
    lo_d      = lo_q;
    lo_full_d = lo_full_q;
    if (abort_i) begin
      state_d   = S_IDLE;
      vld_d     = 1'b0;
      lo_full_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            remain_d  = byte_cnt_i;
            perr_d    = 1'b0;
            lo_full_d = 1'b0;
            if (byte_cnt_i == '0) state_d = S_FLUSH;
            else                  state_d = S_WAIT_REQ;
          end
        end
        S_WAIT_REQ: begin
          if (!scsi_reqn_i) begin
            if (!phase_ok) begin
              perr_d  = 1'b1;
              state_d = S_FLUSH;
            end else if (can_store) begin
              if (lo_full_q) begin
                data_d    = {scsi_di_i, lo_q};
                vld_d     = 1'b1;
                lo_full_d = 1'b0;
              end else begin
                lo_d      = scsi_di_i;
                lo_full_d = 1'b1;
              end
              tmr_d   = '0;
              state_d = S_ACK_ON;
            end
          end
        end
        S_ACK_ON: begin
          if (tmr_q >= HOLD_LAST && scsi_reqn_i) begin
            if (remain_q != '0) remain_d = remain_q - 1'b1;
            tmr_d   = '0;
            state_d = S_ACK_OFF;
          end else if (tmr_q < HOLD_LAST) begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_ACK_OFF: begin
          if (tmr_q >= GAP_LAST) begin
            if (remain_q == '0) state_d = S_FLUSH;
            else                state_d = S_WAIT_REQ;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_FLUSH: begin
          if (lo_full_q) begin
            if (!vld_q || acc) begin
              data_d    = {8'h00, lo_q};
              vld_d     = 1'b1;
              lo_full_d = 1'b0;
            end
          end else if (!vld_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset ignores CE, everything else waits for CE
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      remain_q  <= '0;
      perr_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      lo_q      <= '0;
      lo_full_q <= 1'b0;
    end else if (ce_i) begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      remain_q  <= remain_d;
      perr_q    <= perr_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
      lo_q      <= lo_d;
      lo_full_q <= lo_full_d;
    end
  end

  assign scsi_ackn_o = (state_q != S_ACK_ON);
  assign busy_o      = (state_q != S_IDLE);
  assign wr_data_o   = data_q;
  assign wr_valid_o  = vld_q;
  assign done_o      = done_q;
  assign phase_err_o = perr_q;
  assign remain_o    = remain_q;

endmodule
